// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state encodings and default operand width for serial_sub_ctrl
package serial_sub_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;
endpackage

// File: rtl/serial_sub_ctrl_full_sub.sv
// half_sub / full_sub: one-bit subtractor slice built from two half subtractors and an OR
module half_sub (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bout
);
  assign d    = a ^ b;
  assign bout = ~a & b;
endmodule

module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1, b1, b2;
  half_sub u_hs0 (.a(a),  .b(b),   .d(d1), .bout(b1));
  half_sub u_hs1 (.a(d1), .b(bin), .d(d),  .bout(b2));
  assign bout = b1 | b2;
endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial unsigned a-b, LSB first, one bit per cycle; define SERIAL_SUB_CMP_EN to add eq/lt outputs
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
`ifdef SERIAL_SUB_CMP_EN
  output logic             eq,
  output logic             lt,
`endif
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sd_q, sd_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bor_q, bor_d, bout_q, bout_d, done_q, done_d;
  logic             last, d_bit, b_bit, fin;

  assign last = cnt_q == CW'(WIDTH - 1);
  assign fin  = state_q == S_DONE;

  full_sub u_slice (.a(a_q[0]), .b(b_q[0]), .bin(bor_q), .d(d_bit), .bout(b_bit));

  // next-state: capture in IDLE, shift one bit per RUN cycle, publish result when leaving DONE
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sd_d    = sd_q;
    cnt_d   = cnt_q;
    bor_d   = bor_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RUN;
        a_d     = a;
        b_d     = b;
        cnt_d   = '0;
        bor_d   = 1'b0;
      end
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sd_d    = {d_bit, sd_q[WIDTH-1:1]};
        bor_d   = b_bit;
        cnt_d   = last ? cnt_q : cnt_q + CW'(1);
        state_d = last ? S_DONE : S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
    done_d = fin;
    diff_d = fin ? sd_q : diff_q;
    bout_d = fin ? bor_q : bout_q;
  end

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sd_q    <= '0;
      cnt_q   <= '0;
      bor_q   <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sd_q    <= sd_d;
      cnt_q   <= cnt_d;
      bor_q   <= bor_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

`ifdef SERIAL_SUB_CMP_EN
  logic eq_q, eq_d, lt_q, lt_d;

  // compare flags derive from the finished difference and are published with it
  always_comb begin
    eq_d = fin ? (~bor_q & (sd_q == '0)) : eq_q;
    lt_d = fin ? bor_q : lt_q;
  end

  // compare flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_q <= 1'b0;
      lt_q <= 1'b0;
    end else begin
      eq_q <= eq_d;
      lt_q <= lt_d;
    end
  end

  assign eq = eq_q;
  assign lt = lt_q;
`endif

  assign busy       = state_q == S_RUN;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = bout_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: scoreboard bench driving WIDTH=8 and WIDTH=16 instances with shared random stimulus
module tb_serial_sub_ctrl;
  typedef struct {
    logic [31:0] diff;
    logic        bor;
    logic        eq;
    logic        lt;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy8, done8, bor8, busy16, done16, bor16;
  logic [7:0]  diff8;
  logic [15:0] diff16;
`ifdef SERIAL_SUB_CMP_EN
  logic        eq8, lt8, eq16, lt16;
`endif

  int   errors = 0, checks = 0, cyc = 0;
  int   acc[2], nfree[2], nacc[2];
  exp_t q0[$], q1[$];
  exp_t last[2];

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a[7:0]), .b(b[7:0]),
    .busy(busy8), .done(done8),
`ifdef SERIAL_SUB_CMP_EN
    .eq(eq8), .lt(lt8),
`endif
    .diff(diff8), .borrow_out(bor8)
  );

  serial_sub_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy16), .done(done16),
`ifdef SERIAL_SUB_CMP_EN
    .eq(eq16), .lt(lt16),
`endif
    .diff(diff16), .borrow_out(bor16)
  );

  function automatic int wd(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s w%0d cyc=%0d: got %0h expected %0h", nm, wd(i), cyc, act, exp);
    end
  endtask

  task automatic get_out(input int i, output logic bz, output logic dn, output logic bo,
                         output logic eqv, output logic ltv, output logic [31:0] d);
    bz  = (i == 0) ? busy8 : busy16;
    dn  = (i == 0) ? done8 : done16;
    bo  = (i == 0) ? bor8 : bor16;
    d   = (i == 0) ? {24'b0, diff8} : {16'b0, diff16};
    eqv = 1'b0;
    ltv = 1'b0;
`ifdef SERIAL_SUB_CMP_EN
    eqv = (i == 0) ? eq8 : eq16;
    ltv = (i == 0) ? lt8 : lt16;
`endif
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      acc[i]   = -1000;
      nfree[i] = 0;
      last[i]  = '{32'd0, 1'b0, 1'b0, 1'b0};
    end
  endtask

  task automatic check_zero();
    logic bz, dn, bo, eqv, ltv;
    logic [31:0] d;
    for (int i = 0; i < 2; i++) begin
      get_out(i, bz, dn, bo, eqv, ltv, d);
      chk("rst_busy", i, 32'(bz), 32'd0);
      chk("rst_done", i, 32'(dn), 32'd0);
      chk("rst_diff", i, d, 32'd0);
      chk("rst_borrow", i, 32'(bo), 32'd0);
`ifdef SERIAL_SUB_CMP_EN
      chk("rst_eq", i, 32'(eqv), 32'd0);
      chk("rst_lt", i, 32'(ltv), 32'd0);
`endif
    end
  endtask

  task automatic accept(input int i, input logic [15:0] av, input logic [15:0] bv);
    logic [31:0] m, am, bm;
    exp_t e;
    m  = (i == 0) ? 32'hFF : 32'hFFFF;
    am = {16'b0, av} & m;
    bm = {16'b0, bv} & m;
    e.diff = (am - bm) & m;
    e.bor  = am < bm;
    e.eq   = am == bm;
    e.lt   = am < bm;
    acc[i]   = cyc + 1;
    nfree[i] = acc[i] + wd(i) + 2;
    nacc[i]++;
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic step(input logic s, input logic [15:0] av, input logic [15:0] bv);
    @(negedge clk);
    start = s;
    a     = av;
    b     = bv;
    for (int i = 0; i < 2; i++)
      if (s && rst_n && (cyc + 1 >= nfree[i])) accept(i, av, bv);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'($urandom), 16'($urandom));
  endtask

  initial begin
    logic bz, dn, bo, eqv, ltv;
    logic [31:0] d;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < 2; i++) begin
        get_out(i, bz, dn, bo, eqv, ltv, d);
        chk("busy", i, 32'(bz), 32'(cyc >= acc[i] && cyc < acc[i] + wd(i)));
        chk("done", i, 32'(dn), 32'(cyc == acc[i] + wd(i) + 1));
        chk("busy_done_overlap", i, 32'(bz & dn), 32'd0);
        if (dn) begin
          if ((i == 0 ? q0.size() : q1.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done w%0d cyc=%0d: got done with no pending op", wd(i), cyc);
          end else last[i] = (i == 0) ? q0.pop_front() : q1.pop_front();
        end
        chk("diff", i, d, last[i].diff);
        chk("borrow", i, 32'(bo), 32'(last[i].bor));
`ifdef SERIAL_SUB_CMP_EN
        chk("eq", i, 32'(eqv), 32'(last[i].eq));
        chk("lt", i, 32'(ltv), 32'(last[i].lt));
`endif
      end
    end
  end

  initial begin
    logic [15:0] da[5] = '{16'h0005, 16'h0003, 16'h0000, 16'hFFFF, 16'h0000};
    logic [15:0] db[5] = '{16'h0003, 16'h0005, 16'h0000, 16'hFFFF, 16'hFFFF};
    nacc = '{0, 0};
    model_reset();
    #3 check_zero();
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, da[k], db[k]);
      idle(19);
    end
    repeat (60) step(1'b1, 16'($urandom), 16'($urandom));
    idle(19);
    step(1'b1, 16'h00A5, 16'h003C);
    idle(3);
    #2 rst_n = 1'b0;
    #1 check_zero();
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(1'b1, 16'h0010, 16'h0020);
    idle(19);
    while (nacc[1] < 1000 || nacc[0] < 1000)
      step($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom));
    idle(40);
    chk("drain", 0, 32'(q0.size()), 32'd0);
    chk("drain", 1, 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a subtraction a-b; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend; captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; captured on accepted start.
REQ-007 SHALL have port busy  output  1  high while an operation is in progress (RUN state).
REQ-008 SHALL have port done  output  1  one-cycle pulse when diff/borrow_out are valid.
REQ-009 SHALL have port diff  output  WIDTH  result a-b modulo 2^WIDTH.
REQ-010 SHALL have port borrow_out  output  1  final borrow; 1 when a<b unsigned.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE; no other reachable states.
REQ-012 IDLE: start=1 SHALL capture a and b into shift registers, clear bit counter and running borrow, and enter RUN.
REQ-013 RUN: each cycle SHALL process one bit, LSB first, through the bit-slice subtractor using the running borrow; the difference bit shifts into diff from the MSB side.
REQ-014 RUN SHALL last exactly WIDTH cycles, then enter DONE; counter wraps are not permitted.
REQ-015 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-016 Latency: start sampled at edge N gives done=1 in the cycle after edge N+WIDTH+1; throughput is one operation per WIDTH+2 cycles.
REQ-017 diff and borrow_out SHALL hold the last result from DONE until the next accepted start; in RUN they are don't-care and change only internally.
REQ-018 start while in RUN or DONE SHALL be ignored, with no queuing; changes on a/b after capture SHALL NOT affect the result.
REQ-019 busy SHALL be 1 exactly in RUN; busy and done SHALL never be high together.
REQ-020 WIDTH-wide arithmetic SHALL be unsigned; borrow_out equals the borrow out of the MSB slice.

Reset
REQ-021 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, diff=0, borrow_out=0, counter=0, shift registers=0.
REQ-022 Reset during RUN or DONE SHALL abort the operation; no done pulse SHALL follow release.
REQ-023 After rst_n rises, start SHALL be accepted at the first rising edge.

Configuration
REQ-024 Macro SERIAL_SUB_CMP_EN defined: SHALL add outputs eq (1 bit, a==b) and lt (1 bit, a<b unsigned), updated together with diff and held identically; reset value 0.
REQ-025 Macro SERIAL_SUB_CMP_EN undefined: eq/lt ports and their logic SHALL be absent; all other behaviour identical.

Structure
REQ-026 A shared package/header serial_sub_pkg SHALL hold the state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default WIDTH constant.
REQ-027 A single sub-module full_sub (one-bit a,b,bin -> d,bout), built from two existing half subtractors plus an OR, SHALL be instantiated once as the bit slice.

Verification
REQ-028 WIDTH=8, a=0x05, b=0x03, start pulse -> busy for 8 cycles, done at cycle 10, diff=0x02, borrow_out=0 (eq=0, lt=0 when CMP_EN).
REQ-029 a=0x03, b=0x05 -> diff=0xFE, borrow_out=1 (lt=1).
REQ-030 a=0x00, b=0x00 and a=0xFF, b=0xFF -> diff=0x00, borrow_out=0 (eq=1); a=0x00, b=0xFF -> diff=0x01, borrow_out=1.
REQ-031 Start held high continuously with a changing every cycle -> operations are back-to-back every 10 cycles, each result matching the a/b captured at its accepted start; mid-RUN starts are ignored.
REQ-032 rst_n pulled low at RUN cycle 4 -> all outputs 0 immediately, no done pulse; a new start after release yields a correct result.
REQ-033 Random self-check: 1000 random a/b pairs at WIDTH=8 and WIDTH=16 -> {borrow_out,diff} equals the reference (a-b) with borrow, and busy/done are never high together.
